// File: rtl/vga_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module   : vga_frame_capture
//  Brief    : VGA sink. Tracks the Hsync/Vsync timing of a pixel stream,
//             writes every visible pixel of an armed frame to a frame-buffer
//             write port at its linear address, and flags line/frame lengths
//             that differ from the configured mode.
//  Revision : 1.0  initial release
// ============================================================================
module vga_frame_capture #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int ADDR_W   = 19
) (
    input  logic              ExternalClk,
    input  logic              rstBtn,
    input  logic              PixTick,
    input  logic [7:0]        ColorIn,
    input  logic              HsyncIn,
    input  logic              VsyncIn,
    input  logic              CaptureEn,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [7:0]        WrData,
    output logic              Capturing,
    output logic              FrameDone,
    output logic              LineErr,
    output logic              FrameErr,
    output logic [7:0]        FrameCnt
);

    // Visible window bounds and expected last counts, pre-sized to the counters
    localparam logic [10:0]       c_H_START  = 11'(H_SYNC + H_BACK);
    localparam logic [10:0]       c_H_END    = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0]       c_H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]        c_V_START  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]        c_V_END    = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0]        c_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] c_PIX_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [10:0]       c_H_MAX    = 11'h7FF;
    localparam logic [9:0]        c_V_MAX    = 10'h3FF;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                prev_h_q, prev_h_d;
    logic                prev_v_q, prev_v_d;
    logic [10:0]         hcnt_q, hcnt_d;
    logic [9:0]          vcnt_q, vcnt_d;
    logic                hseen_q, hseen_d;
    logic                vseen_q, vseen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                line_err_q, line_err_d;
    logic                frame_err_q, frame_err_d;

    logic                hfall;
    logic                vfall;
    logic                pix_valid;

    // Sync falling edges relative to the value seen on the previous tick
    assign hfall = prev_h_q & ~HsyncIn;
    assign vfall = prev_v_q & ~VsyncIn;

    // Next-state logic: timing counters, error checks, capture FSM and write port
    always_comb begin
        state_d     = state_q;
        prev_h_d    = prev_h_q;
        prev_v_d    = prev_v_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        hseen_d     = hseen_q;
        vseen_d     = vseen_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;
        pix_valid   = 1'b0;

        if (PixTick) begin
            prev_h_d = HsyncIn;
            prev_v_d = VsyncIn;

            // Horizontal position; length checked against the pre-update count
            if (hfall) begin
                hcnt_d  = '0;
                hseen_d = 1'b1;
                if (hseen_q && (hcnt_q != c_H_LAST)) begin
                    line_err_d = 1'b1;
                end
            end else if (hcnt_q != c_H_MAX) begin
                hcnt_d = hcnt_q + 11'd1;
            end

            // Vertical position; vfall wins over a coincident hfall
            if (vfall) begin
                vcnt_d  = '0;
                vseen_d = 1'b1;
                if (vseen_q && (vcnt_q != c_V_LAST)) begin
                    frame_err_d = 1'b1;
                end
            end else if (hfall && (vcnt_q != c_V_MAX)) begin
                vcnt_d = vcnt_q + 10'd1;
            end

            pix_valid = (state_q == S_CAPTURE)
                     && (hcnt_d >= c_H_START) && (hcnt_d < c_H_END)
                     && (vcnt_d >= c_V_START) && (vcnt_d < c_V_END);

            case (state_q)
                S_IDLE: begin
                    if (vfall && CaptureEn) begin
                        state_d = S_CAPTURE;
                        addr_d  = '0;
                    end
                end
                S_CAPTURE: begin
                    if (vfall) begin
                        // Frame ended before its last pixel: start over
                        addr_d      = '0;
                        frame_err_d = 1'b1;
                    end else if (pix_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = ColorIn;
                        addr_d    = addr_q + ADDR_W'(1);
                        if (addr_q == c_PIX_LAST) begin
                            state_d     = S_IDLE;
                            done_d      = 1'b1;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register with asynchronous reset; sync history resets to idle-high
    always_ff @(posedge ExternalClk or posedge rstBtn) begin
        if (rstBtn) begin
            state_q     <= S_IDLE;
            prev_h_q    <= 1'b1;
            prev_v_q    <= 1'b1;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            hseen_q     <= 1'b0;
            vseen_q     <= 1'b0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_h_q    <= prev_h_d;
            prev_v_q    <= prev_v_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            hseen_q     <= hseen_d;
            vseen_q     <= vseen_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign WrEn      = wr_en_q;
    assign WrAddr    = wr_addr_q;
    assign WrData    = wr_data_q;
    // Stays high through the FrameDone cycle even though the FSM is back in IDLE
    assign Capturing = (state_q == S_CAPTURE) | done_q;
    assign FrameDone = done_q;
    assign LineErr   = line_err_q;
    assign FrameErr  = frame_err_q;
    assign FrameCnt  = frame_cnt_q;

endmodule
`default_nettype wire
